mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM, initiator of the ALU interface.
// Inputs : clk, reset (async, active-high), op/funct from IR, zero from ALU,
//          mem_ready completion handshake from memory.
// Outputs: ALU op/operand selects, memory/IR/PC/regfile strobes, instr_done
//          pulse, sticky err on memory timeout, debug state.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       shift_swap,
  output logic [1:0] ext_op,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       err,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, REXEC, RWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, IEXEC, IWB, JUMP
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_J = 6'h02;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic wait_st, timeout, f_ok, f_sh;
  logic [2:0] f_op;
  // cnt_q counts cycles already spent waiting; the wait aborts on the cycle
  // that would bring it to MEM_TIMEOUT unless mem_ready arrives in that cycle.
  assign wait_st = state_q inside {FETCH, MEMRD, MEMWR};
  assign timeout = wait_st && !mem_ready && ({1'b0, cnt_q} + 9'd1 == 9'(MEM_TIMEOUT));
  assign state   = state_q;
  assign err     = err_q;
  always_comb begin
    f_ok = 1'b1;
    f_sh = 1'b0;
    f_op = 3'b000;
    case (funct)
      6'b100001: f_op = 3'b000;
      6'b100011: f_op = 3'b001;
      6'b100100: f_op = 3'b010;
      6'b100101: f_op = 3'b011;
      6'b000110: begin f_op = 3'b100; f_sh = 1'b1; end
      6'b000111: begin f_op = 3'b101; f_sh = 1'b1; end
      default:   f_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d    = state_q;
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    shift_swap = 1'b0;
    ext_op     = 2'b00;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        // reset parks the FSM here asynchronously; keep its strobes quiet then
        ir_we     = mem_ready && !reset;
        pc_we     = mem_ready && !reset;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        ext_op     = 2'b01;
        state_d    = op == OP_R ? REXEC :
                     (op == OP_LW || op == OP_SW) ? MEMADR :
                     op == OP_BEQ ? BRANCH :
                     (op == OP_ORI || op == OP_LUI) ? IEXEC :
                     op == OP_J ? JUMP : FETCH;
        instr_done = state_d == FETCH;
      end
      REXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = f_op;
        shift_swap = f_sh;
        state_d    = f_ok ? RWB : FETCH;
        instr_done = !f_ok;
      end
      RWB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
        state_d   = op == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_rd  = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_wr     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? FETCH : MEMWR;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_src     = 2'b01;
        pc_we      = zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = op == OP_LUI ? 2'b10 : 2'b00;
        alu_op    = op == OP_LUI ? 3'b000 : 3'b011;
        state_d   = IWB;
      end
      IWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_we      = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (timeout) state_d = FETCH;
    err_d = err_q || timeout;
    cnt_d = (wait_st && !mem_ready && !timeout) ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: instruction-level model of mc_ctrl checked against the DUT every cycle
module tb_mc_ctrl;
  localparam int MEM_TIMEOUT = 16;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       shift_swap;
    logic [1:0] ext_op;
    logic       iord, mem_rd, mem_wr, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, instr_done, err;
    logic [3:0] state;
  } ctl_t;
  typedef struct {
    logic       mr, z;
    logic [5:0] op, funct;
    ctl_t       e;
  } cyc_t;
  logic clk = 0, reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic [2:0] alu_op;
  logic alu_src_a, shift_swap, iord, mem_rd, mem_wr, ir_we, pc_we;
  logic reg_we, reg_dst, mem_to_reg, instr_done, err;
  logic [1:0] alu_src_b, ext_op, pc_src;
  logic [3:0] state;
  ctl_t dut_w;
  cyc_t q[$];
  cyc_t cur;
  bit live = 0;
  bit err_m = 0;
  logic [5:0] cur_op, cur_f;
  logic cur_z;
  int checks = 0, failures = 0, done_cnt = 0, regwe_cnt = 0;

  mc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .shift_swap(shift_swap),
    .ext_op(ext_op), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .err(err), .state(state)
  );

  always #5 clk = ~clk;
  assign dut_w = {alu_op, alu_src_a, alu_src_b, shift_swap, ext_op, iord, mem_rd, mem_wr,
                  ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, instr_done, err, state};

  always @(negedge clk) begin
    if (live) begin
      checks++;
      if (dut_w !== cur.e) begin
        failures++;
        $display("FAIL cycle op=%h funct=%h exp_state=%0d got=%h exp=%h", cur.op, cur.funct,
                 cur.e.state, dut_w, cur.e);
      end
    end
    if (!reset) begin
      done_cnt  += int'(instr_done);
      regwe_cnt += int'(reg_we);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // control word of each phase; phases numbered FETCH=0 .. JUMP=11 in listing order
  function automatic ctl_t pw(input int s);
    ctl_t c = '0;
    c.state = 4'(s);
    case (s)
      0:  begin c.mem_rd = 1; c.alu_src_b = 2'b01; end
      1:  begin c.alu_src_b = 2'b11; c.ext_op = 2'b01; end
      2:  c.alu_src_a = 1;
      3:  begin c.reg_we = 1; c.reg_dst = 1; c.instr_done = 1; end
      4:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 2'b01; end
      5:  begin c.mem_rd = 1; c.iord = 1; end
      6:  begin c.reg_we = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      7:  begin c.mem_wr = 1; c.iord = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.instr_done = 1; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: begin c.reg_we = 1; c.instr_done = 1; end
      default: begin c.pc_we = 1; c.pc_src = 2'b10; c.instr_done = 1; end
    endcase
    return c;
  endfunction

  function automatic void push(input logic mr, input ctl_t c);
    c.err = err_m;
    q.push_back('{mr, cur_z, cur_op, cur_f, c});
  endfunction

  // R-type: the ALU code is the position of funct in this list
  function automatic void rfunct(input logic [5:0] f, output logic [2:0] a, output bit sh,
                                 output bit ok);
    logic [5:0] fs [6] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h06, 6'h07};
    a = 0; sh = 0; ok = 0;
    for (int i = 0; i < 6; i++)
      if (f == fs[i]) begin a = 3'(i); sh = i >= 4; ok = 1; end
  endfunction

  // w cycles without mem_ready then one ready cycle, or an abort after MEM_TIMEOUT idle cycles
  task automatic wait_phase(input int s, input int w, output bit ab);
    ctl_t c;
    ab = 0;
    for (int i = 0; i < w; i++) begin
      push(0, pw(s));
      if (i + 1 == MEM_TIMEOUT) begin err_m = 1; ab = 1; return; end
    end
    c = pw(s);
    if (s == 0) begin c.ir_we = 1; c.pc_we = 1; end
    if (s == 7) c.instr_done = 1;
    push(1, c);
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                       input logic z);
    ctl_t c;
    bit ab, sh, ok;
    logic [2:0] a;
    cur_op = o; cur_f = f; cur_z = z;
    wait_phase(0, fw, ab);
    if (ab) return;
    c = pw(1);
    if (!(o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h0d, 6'h0f, 6'h02})) begin
      c.instr_done = 1; push(1, c); return;
    end
    push(1, c);
    if (o == 6'h00) begin
      rfunct(f, a, sh, ok);
      c = pw(2); c.alu_op = a; c.shift_swap = sh; c.instr_done = !ok;
      push(1, c);
      if (ok) push(1, pw(3));
    end else if (o == 6'h23 || o == 6'h2b) begin
      push(1, pw(4));
      wait_phase(o == 6'h23 ? 5 : 7, mw, ab);
      if (!ab && o == 6'h23) push(1, pw(6));
    end else if (o == 6'h04) begin
      c = pw(8); c.pc_we = z; push(1, c);
    end else if (o == 6'h0d || o == 6'h0f) begin
      c = pw(9);
      c.ext_op = o == 6'h0f ? 2'b10 : 2'b00;
      c.alu_op = o == 6'h0f ? 3'b000 : 3'b011;
      push(1, c);
      push(1, pw(10));
    end else push(1, pw(11));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) begin
      cur = q.pop_front();
      mem_ready = cur.mr; zero = cur.z; op = cur.op; funct = cur.funct;
      live = 1;
      @(posedge clk);
      #1;
    end
    live = 0;
  endtask

  task automatic run_q();
    run_n(100000);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, act, exp);
    end
  endtask

  initial begin
    int d0, r0;
    reset = 1; mem_ready = 0; zero = 0; op = 0; funct = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_rd", mem_rd, 1);
    mem_ready = 1;
    #1;
    chk("rst_pc_we_ready", pc_we, 0);
    @(posedge clk);
    #1;
    reset = 0;
    mem_ready = 0;

    instr(6'h00, 6'h21, 0, 0, 0);
    chk("addu_len", q.size(), 4);
    d0 = done_cnt;
    run_q();
    chk("addu_done_pulses", done_cnt - d0, 1);

    instr(6'h00, 6'h07, 1, 0, 0);
    instr(6'h00, 6'h23, 0, 0, 0);
    run_q();
    instr(6'h00, 6'h2a, 0, 0, 0);
    chk("badfunct_len", q.size(), 3);
    r0 = regwe_cnt;
    run_q();
    chk("badfunct_no_write", regwe_cnt - r0, 0);

    instr(6'h23, 6'h00, 0, 3, 0);
    chk("lw_len", q.size(), 8);
    run_q();

    instr(6'h04, 6'h00, 0, 0, 1);
    instr(6'h04, 6'h00, 2, 0, 0);
    instr(6'h0d, 6'h00, 0, 0, 0);
    instr(6'h0f, 6'h00, 0, 0, 1);
    instr(6'h02, 6'h00, 0, 0, 0);
    instr(6'h3f, 6'h00, 0, 0, 0);
    instr(6'h2b, 6'h00, 0, 0, 0);
    run_q();

    instr(6'h2b, 6'h00, 0, MEM_TIMEOUT - 1, 0);
    chk("sw_edge_len", q.size(), 3 + MEM_TIMEOUT);
    run_q();
    chk("sw_edge_no_err", err, 0);

    instr(6'h2b, 6'h00, 0, MEM_TIMEOUT, 0);
    chk("sw_timeout_len", q.size(), 3 + MEM_TIMEOUT);
    r0 = regwe_cnt;
    run_q();
    chk("sw_timeout_err", err, 1);
    chk("sw_timeout_state", state, 0);
    instr(6'h00, 6'h24, 0, 0, 0);
    instr(6'h23, 6'h00, 1, MEM_TIMEOUT, 0);
    instr(6'h00, 6'h25, 0, 0, 0);
    run_q();
    chk("err_sticky", err, 1);
    chk("timeout_regwe", regwe_cnt - r0, 2);

    instr(6'h23, 6'h00, 0, 5, 0);
    run_n(5);
    q.delete();
    mem_ready = 1;
    reset = 1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_ir_we", ir_we, 0);
    chk("midrst_pc_we", pc_we, 0);
    chk("midrst_reg_we", reg_we, 0);
    chk("midrst_done", instr_done, 0);
    chk("midrst_err", err, 0);
    @(posedge clk);
    #1;
    reset = 0;
    mem_ready = 0;
    err_m = 0;
    instr(6'h00, 6'h06, 0, 0, 0);
    instr(6'h0f, 6'h00, 0, 0, 0);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
